tx_down_counter: RTL and testbench

Parametrised loadable down-counter for the serial transmit path. It counts bit or byte slots for a transmitter: it loads a slot count, decrements on each enable and flags terminal count. Beyond a plain down-counter it adds a run/idle state machine, one-shot or auto-reload mode, an abort input and a registered done pulse. It keeps the legacy `tc` (zero-and-idle) output so existing controllers can migrate unchanged.

---
 rtl/tx_cnt_pkg.sv | 12 +
 rtl/tx_period_sat.sv | 35 +++
 rtl/tx_down_counter.sv | 96 +++++++++
 tb/tb_tx_down_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tx_cnt_pkg.sv
// Shared types and default widths for the transmit slot counter.
package tx_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  localparam int unsigned TX_CNT_W    = 8;
  localparam int unsigned TX_PERIOD_W = 8;

endpackage

// File: rtl/tx_period_sat.sv
// Saturating completed-period counter; clr wins over en.
module tx_period_sat
  import tx_cnt_pkg::*;
#(
  parameter int unsigned W = TX_PERIOD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tx_down_counter.sv
// Loadable down-counter for transmit slots with run/idle FSM, auto-reload,
// abort and a registered done pulse. Define TXCNT_PERIOD_CNT_EN for period_cnt.
module tx_down_counter
  import tx_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = TX_CNT_W,
  parameter int unsigned PERIOD_W = TX_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                cnt_en,
  input  logic                auto_reload,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                done,
`ifdef TXCNT_PERIOD_CNT_EN
  output logic                tc,
  output logic [PERIOD_W-1:0] period_cnt
`else
  output logic                tc
`endif
);

  if (WIDTH < 2 || PERIOD_W < 1) begin : g_param_check
    $error("tx_down_counter: WIDTH must be >= 2 and PERIOD_W >= 1");
  end

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // RUN is only entered with a non-zero count, so count_q==0 in RUN cannot occur;
  // the hold fallback just keeps the counter from ever wrapping.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (abort) begin
      state_d = IDLE;
    end else if ((state_q == RUN) && cnt_en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign tc    = ~|{cnt_en, count_q};

`ifdef TXCNT_PERIOD_CNT_EN
  // Counts alongside done: steps on the same edge that sets the done flop.
  tx_period_sat #(
    .W (PERIOD_W)
  ) u_period_sat (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (done_d),
    .cnt (period_cnt)
  );
`endif

endmodule

// File: tb/tb_tx_down_counter.sv
// Self-checking bench for tx_down_counter: vector table plus scoreboard queue.
module tb_tx_down_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         cnt_en;
  logic         auto_reload;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;
`ifdef TXCNT_PERIOD_CNT_EN
  logic [PW-1:0] period_cnt;
`endif

  tx_down_counter #(
    .WIDTH    (W),
    .PERIOD_W (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .cnt_en      (cnt_en),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
`ifdef TXCNT_PERIOD_CNT_EN
    .tc          (tc),
    .period_cnt  (period_cnt)
`else
    .tc          (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         ar;
    logic         ab;
    int           e_count;
    logic         e_busy;
    logic         e_done;
    logic         e_tc;
    int           e_pc;   // -1: do not check period_cnt
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic ld, int lv, logic en, logic ar, logic ab,
                              int ec, logic eb, logic ed, logic et, int epc);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = W'(lv); v.en = en; v.ar = ar; v.ab = ab;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rst = v.rst; load = v.load; load_val = v.lv;
    cnt_en = v.en; auto_reload = v.ar; abort = v.ab;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".count"}, int'(count), e.e_count);
    chk({tag, ".busy"},  int'(busy),  int'(e.e_busy));
    chk({tag, ".done"},  int'(done),  int'(e.e_done));
    chk({tag, ".tc"},    int'(tc),    int'(e.e_tc));
`ifdef TXCNT_PERIOD_CNT_EN
    if (e.e_pc >= 0) chk({tag, ".period_cnt"}, int'(period_cnt), e.e_pc);
`endif
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; cnt_en = 1'b0; auto_reload = 1'b0; abort = 1'b0;

    //           rst ld  lv en ar ab | cnt busy done tc  pc
    tbl.push_back(mk(1, 0,  0, 0, 0, 0,   0, 0, 0, 1,  0));  // reset
    tbl.push_back(mk(1, 0,  0, 0, 0, 0,   0, 0, 0, 1,  0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,   0, 0, 0, 1,  0));  // idle
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   0, 0, 0, 0, -1));  // en ignored in idle, tc drops
    tbl.push_back(mk(0, 1,  3, 0, 0, 0,   3, 1, 0, 0,  0));  // one-shot load 3
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   2, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   0, 0, 1, 0,  1));  // terminal
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,   0, 0, 0, 1,  1));
    tbl.push_back(mk(0, 1,  2, 0, 1, 0,   2, 1, 0, 0,  0));  // auto-reload load 2
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   2, 1, 1, 0,  1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   2, 1, 1, 0,  2));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   2, 1, 1, 0,  3));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0,  3));  // count=1 in RUN
    tbl.push_back(mk(0, 1,  5, 1, 1, 0,   5, 1, 0, 0,  0));  // load beats terminal
    tbl.push_back(mk(0, 0,  0, 1, 1, 1,   5, 0, 0, 0, -1));  // abort holds count
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   5, 0, 0, 0, -1));  // idle ignores en
    tbl.push_back(mk(0, 1,  0, 0, 0, 0,   0, 0, 0, 1,  0));  // load zero
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   0, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1,  2, 0, 0, 0,   2, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(1, 0,  0, 1, 0, 0,   0, 0, 0, 0,  0));  // reset suppresses done
    tbl.push_back(mk(0, 1,  2, 0, 1, 0,   2, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0,   1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   0, 0, 1, 0,  1));  // ar sampled at terminal
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,   0, 0, 0, 0,  1));

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Load 200, ten enables, then reset mid-run.
    apply(mk(0, 1, 200, 0, 0, 0, 200, 1, 0, 0, 0), "l200");
    for (int i = 1; i <= 10; i++) begin
      apply(mk(0, 0, 0, 1, 0, 0, 200 - i, 1, 0, 0, -1), $sformatf("l200_en%0d", i));
    end
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "l200_rst");

    // Max load: 255 enables per period, done only on the last.
    apply(mk(0, 1, 255, 0, 0, 0, 255, 1, 0, 0, 0), "max_load");
    for (int i = 1; i <= 255; i++) begin
      apply(mk(0, 0, 0, 1, 0, 0, 255 - i, (i < 255), (i == 255), 0, -1),
            $sformatf("max_en%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "max_after");

    // Reload value 1: every enable is terminal; period_cnt saturates at 3.
    apply(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0), "sat_load");
    for (int i = 1; i <= 6; i++) begin
      apply(mk(0, 0, 0, 1, 1, 0, 1, 1, 1, 0, (i < 3) ? i : 3), $sformatf("sat_en%0d", i));
    end
    apply(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1 == 0, 3), "sat_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
